// File: rtl/l2recv_if.sv
// Bus-side and L2-side signal bundle of the L2 bus receiver.
// The slave view is the receiver; the master view drives the bus and the L2 ready inputs.
interface l2recv_if;
    // Handshake rule for both fill and snp: the producer raises valid and holds
    // every payload bit stable until a cycle with valid && ready, which is the transfer.
    logic         bus_valid;
    logic         bus_nack;
    logic [2:0]   bus_cmd;
    logic [4:0]   bus_tag;
    logic [29:0]  bus_addr;
    logic [63:0]  bus_data;

    logic         l2recv_l2_fill_valid;
    logic [25:0]  l2recv_l2_fill_addr;
    logic [511:0] l2recv_l2_fill_data;
    logic         l2_l2recv_fill_ready;

    logic         l2recv_l2_snp_valid;
    logic [2:0]   l2recv_l2_snp_cmd;
    logic [25:0]  l2recv_l2_snp_addr;
    logic         l2_l2recv_snp_ready;

    logic         l2recv_bus_nack;
    logic         l2recv_err;
    logic [1:0]   dbg_state;

    modport slave (
        input  bus_valid, bus_nack, bus_cmd, bus_tag, bus_addr, bus_data,
        input  l2_l2recv_fill_ready, l2_l2recv_snp_ready,
        output l2recv_l2_fill_valid, l2recv_l2_fill_addr, l2recv_l2_fill_data,
        output l2recv_l2_snp_valid, l2recv_l2_snp_cmd, l2recv_l2_snp_addr,
        output l2recv_bus_nack, l2recv_err, dbg_state
    );

    modport master (
        output bus_valid, bus_nack, bus_cmd, bus_tag, bus_addr, bus_data,
        output l2_l2recv_fill_ready, l2_l2recv_snp_ready,
        input  l2recv_l2_fill_valid, l2recv_l2_fill_addr, l2recv_l2_fill_data,
        input  l2recv_l2_snp_valid, l2recv_l2_snp_cmd, l2recv_l2_snp_addr,
        input  l2recv_bus_nack, l2recv_err, dbg_state
    );
endinterface

// File: rtl/l2recv.sv
// L2 bus receiver: captures critical-word-first DATA responses for TAG into a
// single-entry line buffer and forwards foreign snoops through a NACK window.
module l2recv #(
    parameter logic [4:0] TAG = 5'd0
) (
    input logic     clk,
    input logic     rst,
    l2recv_if.slave bif
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        SKIP     = 2'd2,
        SNP_HOLD = 2'd3
    } state_t;

    localparam logic [2:0] CMD_READ = 3'd0;
    localparam logic [2:0] CMD_RDX  = 3'd1;
    localparam logic [2:0] CMD_UPGR = 3'd2;
    localparam logic [2:0] CMD_WB   = 3'd3;
    localparam logic [2:0] CMD_DATA = 3'd4;

    state_t       state_q, state_d;
    logic [2:0]   beat_q, beat_d;
    logic [2:0]   start_q, start_d;

    logic         fill_valid_q, fill_valid_d;
    logic [25:0]  fill_addr_q, fill_addr_d;
    logic [511:0] fill_data_q, fill_data_d;

    logic         stg_wb_q, stg_wb_d;
    logic [2:0]   stg_cmd_q, stg_cmd_d;
    logic [25:0]  stg_addr_q, stg_addr_d;

    logic         snp_valid_q, snp_valid_d;
    logic [2:0]   snp_cmd_q, snp_cmd_d;
    logic [25:0]  snp_addr_q, snp_addr_d;

    logic         nack_q, nack_d;
    logic         err_q, err_d;

    logic         header;
    logic [2:0]   widx;
    logic [8:0]   wbase;
    logic         unused_addr_bit;

    assign unused_addr_bit = bif.bus_addr[0];

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        start_d      = start_q;
        fill_valid_d = fill_valid_q;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        stg_wb_d     = stg_wb_q;
        stg_cmd_d    = stg_cmd_q;
        stg_addr_d   = stg_addr_q;
        snp_valid_d  = snp_valid_q;
        snp_cmd_d    = snp_cmd_q;
        snp_addr_d   = snp_addr_q;
        nack_d       = 1'b0;
        err_d        = err_q;
        widx         = start_q + beat_q;
        wbase        = {widx, 6'd0};

        if (fill_valid_q && bif.l2_l2recv_fill_ready) begin
            fill_valid_d = 1'b0;
        end
        if (snp_valid_q && bif.l2_l2recv_snp_ready) begin
            snp_valid_d = 1'b0;
        end

        // A staged WB owns the following valid cycles as data, so it never sees a header there.
        header = bif.bus_valid &&
                 ((state_q == IDLE) || ((state_q == SNP_HOLD) && !stg_wb_q));

        case (state_q)
            FILL: begin
                if (bif.bus_valid) begin
                    fill_data_d[wbase +: 64] = bif.bus_data;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        fill_valid_d = 1'b1;
                        state_d      = IDLE;
                        beat_d       = 3'd0;
                    end
                end
            end
            SKIP: begin
                if (bif.bus_valid) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                        beat_d  = 3'd0;
                    end
                end
            end
            SNP_HOLD: begin
                // nack_q set means the output register was occupied at header time.
                if (!bif.bus_nack && !nack_q) begin
                    snp_valid_d = 1'b1;
                    snp_cmd_d   = stg_cmd_q;
                    snp_addr_d  = stg_addr_q;
                end
                state_d = IDLE;
                if (stg_wb_q) begin
                    state_d = SKIP;
                    beat_d  = bif.bus_valid ? 3'd1 : 3'd0;
                end
            end
            default: ;
        endcase

        if (header) begin
            case (bif.bus_cmd)
                CMD_DATA: begin
                    beat_d = 3'd0;
                    if ((bif.bus_tag == TAG) && !fill_valid_q) begin
                        state_d     = FILL;
                        fill_addr_d = bif.bus_addr[29:4];
                        start_d     = bif.bus_addr[3:1];
                    end else begin
                        if (bif.bus_tag == TAG) begin
                            err_d = 1'b1;
                        end
                        state_d = SKIP;
                    end
                end
                CMD_READ, CMD_RDX, CMD_UPGR, CMD_WB: begin
                    if (bif.bus_tag != TAG) begin
                        stg_wb_d   = (bif.bus_cmd == CMD_WB);
                        stg_cmd_d  = bif.bus_cmd;
                        stg_addr_d = bif.bus_addr[29:4];
                        state_d    = SNP_HOLD;
                        // snp_valid_d already folds in this cycle's accept and any load.
                        nack_d     = snp_valid_d;
                    end else if (bif.bus_cmd == CMD_WB) begin
                        state_d = SKIP;
                        beat_d  = 3'd0;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= 3'd0;
            start_q      <= 3'd0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= 26'd0;
            fill_data_q  <= 512'd0;
            stg_wb_q     <= 1'b0;
            stg_cmd_q    <= 3'd0;
            stg_addr_q   <= 26'd0;
            snp_valid_q  <= 1'b0;
            snp_cmd_q    <= 3'd0;
            snp_addr_q   <= 26'd0;
            nack_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            start_q      <= start_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
            stg_wb_q     <= stg_wb_d;
            stg_cmd_q    <= stg_cmd_d;
            stg_addr_q   <= stg_addr_d;
            snp_valid_q  <= snp_valid_d;
            snp_cmd_q    <= snp_cmd_d;
            snp_addr_q   <= snp_addr_d;
            nack_q       <= nack_d;
            err_q        <= err_d;
        end
    end

    assign bif.l2recv_l2_fill_valid = fill_valid_q;
    assign bif.l2recv_l2_fill_addr  = fill_addr_q;
    assign bif.l2recv_l2_fill_data  = fill_data_q;
    assign bif.l2recv_l2_snp_valid  = snp_valid_q;
    assign bif.l2recv_l2_snp_cmd    = snp_cmd_q;
    assign bif.l2recv_l2_snp_addr   = snp_addr_q;
    assign bif.l2recv_bus_nack      = nack_q;
    assign bif.l2recv_err           = err_q;
    assign bif.dbg_state            = state_q;
endmodule
